// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state encodings, write-beat type
// and the byte-strobe merge helper used by the register file.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] W_RST  = 3'd0;
   localparam logic [2:0] W_IDLE = 3'd1;
   localparam logic [2:0] W_ADDR = 3'd2;
   localparam logic [2:0] W_DATA = 3'd3;
   localparam logic [2:0] W_RESP = 3'd4;

   localparam logic [1:0] R_RST  = 2'd0;
   localparam logic [1:0] R_IDLE = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } wbeat_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the register slave; master drives requests, slave answers.
interface axi_lite_slave_regs_if #(parameter int ADDR_W = 32);

   logic [ADDR_W-1:0] S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [ADDR_W-1:0] S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/axi_lite_slave_regfile.sv
// Byte-strobed 32-bit register array with a combinational read port; reads see the
// value before any write landing on the same edge.
module axi_lite_slave_regfile
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  wbeat_t           wbeat,
   input  logic [IDX_W-1:0] ridx,
   output logic [31:0]      rdata
);

   logic [31:0] regs [NUM_REGS];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (widx == IDX_W'(i)) regs[i] <= strb_merge(regs[i], wbeat.data, wbeat.strb);
      end
   end

   assign rdata = regs[ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with independent AW/W acceptance.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   axi_lite_slave_regs_if.slave  s_axi
);

   localparam int IDX_W = $clog2(NUM_REGS);

`ifdef AXIL_SLV_DECERR_EN
   localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

   logic [2:0]        w_state;
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] aw_addr_q;
   wbeat_t            w_beat_q;
   logic [1:0]        bresp_q;
   logic [31:0]       rdata_q;
   logic [1:0]        rresp_q;

   logic              aw_hs, w_hs, commit;
   logic [ADDR_W-1:0] wr_addr;
   wbeat_t            wr_beat;
   logic              wr_in_range, ar_in_range;
   logic [31:0]       rf_rdata;

   // Handshake readiness is a pure function of state.
   assign s_axi.S_AXI_AWREADY = (w_state == W_IDLE) || (w_state == W_DATA);
   assign s_axi.S_AXI_WREADY  = (w_state == W_IDLE) || (w_state == W_ADDR);
   assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = (r_state == R_IDLE);
   assign s_axi.S_AXI_RVALID  = (r_state == R_DATA);
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;

   assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
   assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;

   // Whichever half arrived earlier comes from its holding register.
   always_comb begin
      wr_addr = (w_state == W_ADDR) ? aw_addr_q : s_axi.S_AXI_AWADDR;
      wr_beat = (w_state == W_DATA) ? w_beat_q
                                    : wbeat_t'{data: s_axi.S_AXI_WDATA, strb: s_axi.S_AXI_WSTRB};
   end

   assign commit = ((w_state == W_IDLE) && aw_hs && w_hs) ||
                   ((w_state == W_ADDR) && w_hs) ||
                   ((w_state == W_DATA) && aw_hs);

   assign wr_in_range = (wr_addr >> (2 + IDX_W)) == '0;
   assign ar_in_range = (s_axi.S_AXI_ARADDR >> (2 + IDX_W)) == '0;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state   <= W_RST;
         aw_addr_q <= '0;
         w_beat_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (commit) bresp_q <= wr_in_range ? RESP_OKAY : OOR_RESP;
         case (w_state)
            W_RST:  w_state <= W_IDLE;
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  w_state <= W_RESP;
               end else if (aw_hs) begin
                  aw_addr_q <= s_axi.S_AXI_AWADDR;
                  w_state   <= W_ADDR;
               end else if (w_hs) begin
                  w_beat_q <= wr_beat;
                  w_state  <= W_DATA;
               end
            end
            W_ADDR: if (w_hs)  w_state <= W_RESP;
            W_DATA: if (aw_hs) w_state <= W_RESP;
            W_RESP: if (s_axi.S_AXI_BREADY) w_state <= W_IDLE;
            default: w_state <= W_RST;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= R_RST;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         case (r_state)
            R_RST:  r_state <= R_IDLE;
            R_IDLE: if (s_axi.S_AXI_ARVALID) begin
               rdata_q <= ar_in_range ? rf_rdata : '0;
               rresp_q <= ar_in_range ? RESP_OKAY : OOR_RESP;
               r_state <= R_DATA;
            end
            R_DATA: if (s_axi.S_AXI_RREADY) r_state <= R_IDLE;
            default: r_state <= R_RST;
         endcase
      end
   end

   axi_lite_slave_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_regfile (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .we      (commit && wr_in_range),
      .widx    (wr_addr[2 +: IDX_W]),
      .wbeat   (wr_beat),
      .ridx    (s_axi.S_AXI_ARADDR[2 +: IDX_W]),
      .rdata   (rf_rdata)
   );

   // Protection bits and sub-word address bits carry no meaning here.
   logic unused_sig;
   assign unused_sig = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: an array model of the registers predicts
// every response, a negedge monitor checks each valid beat against it.
module tb_axi_lite_slave_regs;

   localparam int NUM_REGS = 4;
   localparam int ADDR_W   = 32;
   localparam int IDX_W    = $clog2(NUM_REGS);

`ifdef AXIL_SLV_DECERR_EN
   localparam logic [1:0] OOR = 2'b10;
`else
   localparam logic [1:0] OOR = 2'b00;
`endif

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   axi_lite_slave_regs_if #(.ADDR_W(ADDR_W)) bus ();

   axi_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .s_axi   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Register model and outstanding-response bookkeeping
   logic [31:0] mdl [NUM_REGS];
   int b_exp = 0, b_done = 0, r_exp = 0, r_done = 0;
   logic [1:0]  exp_bresp = 2'b00;
   logic [31:0] exp_rdata = 32'h0;
   logic [1:0]  exp_rresp = 2'b00;

   function automatic bit in_rng(input logic [31:0] a);
      return (a >> (2 + IDX_W)) == 0;
   endfunction

   function automatic logic [31:0] mdl_read(input logic [31:0] a);
      return in_rng(a) ? mdl[a[2 +: IDX_W]] : 32'h0;
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;
   endtask

   always @(negedge ACLK) begin
      if (ARESETn) begin
         if (bus.S_AXI_BVALID) begin
            chk("bvalid_outstanding", 32'(b_done < b_exp), 32'd1);
            chk("bresp", 32'(bus.S_AXI_BRESP), 32'(exp_bresp));
            chk("awready_during_b", 32'(bus.S_AXI_AWREADY), 32'd0);
            chk("wready_during_b", 32'(bus.S_AXI_WREADY), 32'd0);
            if (bus.S_AXI_BREADY) b_done++;
         end
         if (bus.S_AXI_RVALID) begin
            chk("rvalid_outstanding", 32'(r_done < r_exp), 32'd1);
            chk("rdata", bus.S_AXI_RDATA, exp_rdata);
            chk("rresp", 32'(bus.S_AXI_RRESP), 32'(exp_rresp));
            chk("arready_during_r", 32'(bus.S_AXI_ARREADY), 32'd0);
            if (bus.S_AXI_RREADY) r_done++;
         end
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
      bit aw_done = 0, w_done = 0, af, wf;
      int cyc = 0;
      @(posedge ACLK); #1;
      exp_bresp = in_rng(addr) ? 2'b00 : OOR;
      while (!(aw_done && w_done) && cyc < 40) begin
         bus.S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
         bus.S_AXI_AWADDR  = bus.S_AXI_AWVALID ? addr : 32'hDEAD_BEE0;
         bus.S_AXI_WVALID  = !w_done && cyc >= w_dly;
         bus.S_AXI_WDATA   = bus.S_AXI_WVALID ? data : 32'h5A5A_5A5A;
         bus.S_AXI_WSTRB   = bus.S_AXI_WVALID ? strb : 4'hF;
         @(negedge ACLK);
         af = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         wf = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         @(posedge ACLK); #1;
         aw_done |= af;
         w_done  |= wf;
         cyc++;
      end
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_AWADDR  = 32'hDEAD_BEE0;
      bus.S_AXI_WDATA   = 32'h5A5A_5A5A;
      if (!(aw_done && w_done)) begin
         chk("write_handshake_timeout", 32'd0, 32'd1);
         return;
      end
      if (in_rng(addr))
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[addr[2 +: IDX_W]][8*b +: 8] = data[8*b +: 8];
      b_exp++;
      @(negedge ACLK);
      chk("bvalid_latency", 32'(bus.S_AXI_BVALID), 32'd1);
      for (int i = 0; i < b_dly; i++) begin
         @(negedge ACLK);
         chk("bvalid_held", 32'(bus.S_AXI_BVALID), 32'd1);
      end
      @(posedge ACLK); #1;
      bus.S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      bus.S_AXI_BREADY = 1'b0;
      @(negedge ACLK);
      chk("bvalid_cleared", 32'(bus.S_AXI_BVALID), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      bit fired = 0;
      int cyc = 0;
      data = 32'hX;
      resp = 2'bXX;
      @(posedge ACLK); #1;
      exp_rdata = mdl_read(addr);
      exp_rresp = in_rng(addr) ? 2'b00 : OOR;
      while (!fired && cyc < 40) begin
         bus.S_AXI_ARVALID = 1'b1;
         bus.S_AXI_ARADDR  = addr;
         @(negedge ACLK);
         fired = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
         @(posedge ACLK); #1;
         cyc++;
      end
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_ARADDR  = 32'hDEAD_BEE0;
      if (!fired) begin
         chk("read_handshake_timeout", 32'd0, 32'd1);
         return;
      end
      r_exp++;
      @(negedge ACLK);
      chk("rvalid_latency", 32'(bus.S_AXI_RVALID), 32'd1);
      data = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
      for (int i = 0; i < r_dly; i++) begin
         @(negedge ACLK);
         chk("rvalid_held", 32'(bus.S_AXI_RVALID), 32'd1);
      end
      @(posedge ACLK); #1;
      bus.S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      bus.S_AXI_RREADY = 1'b0;
      @(negedge ACLK);
      chk("rvalid_cleared", 32'(bus.S_AXI_RVALID), 32'd0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd0);
      chk({tag, "_wready"},  32'(bus.S_AXI_WREADY),  32'd0);
      chk({tag, "_bvalid"},  32'(bus.S_AXI_BVALID),  32'd0);
      chk({tag, "_bresp"},   32'(bus.S_AXI_BRESP),   32'd0);
      chk({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd0);
      chk({tag, "_rvalid"},  32'(bus.S_AXI_RVALID),  32'd0);
      chk({tag, "_rdata"},   bus.S_AXI_RDATA,        32'd0);
      chk({tag, "_rresp"},   32'(bus.S_AXI_RRESP),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r, r2;
      logic [31:0] lit [NUM_REGS];
      bit af;
      int cyc;

      bus.S_AXI_AWADDR = 32'h0;  bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA  = 32'h0;  bus.S_AXI_WSTRB  = 4'h0;   bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = 32'h0;  bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      mdl_clear();

      // Reset state, and the one-cycle RST state after release
      #1;
      chk_outputs_zero("reset");
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      #1;
      chk("rst_state_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      chk("rst_state_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
      @(posedge ACLK); #1;
      chk("idle_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
      chk("idle_wready",  32'(bus.S_AXI_WREADY),  32'd1);
      chk("idle_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

      // Same-cycle AW/W, then read back
      bus.S_AXI_AWPROT = 3'b111;
      bus.S_AXI_ARPROT = 3'b101;
      do_write(32'h4, 32'h1234_5678, 4'hF, 0, 0, 0);
      do_read(32'h4, 0, d, r);
      chk("lit_reg1", d, 32'h1234_5678);
      chk("lit_reg1_resp", 32'(r), 32'd0);

      // AW three cycles ahead of W, then the reverse
      do_write(32'h8, 32'hCAFE_F00D, 4'hF, 0, 3, 0);
      do_read(32'h8, 0, d, r);
      chk("lit_reg2_aw_first", d, 32'hCAFE_F00D);
      do_write(32'hC, 32'h0BAD_BEEF, 4'hF, 3, 0, 0);
      do_read(32'hC, 0, d, r);
      chk("lit_reg3_w_first", d, 32'h0BAD_BEEF);

      // Partial strobe, sub-word address bits ignored, empty strobe
      do_write(32'h4, 32'hAAAA_BBBB, 4'b0011, 0, 0, 0);
      do_read(32'h4, 0, d, r);
      chk("lit_strobe_0011", d, 32'h1234_BBBB);
      do_read(32'h7, 0, d, r);
      chk("lit_low_bits_ignored", d, 32'h1234_BBBB);
      do_write(32'h4, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
      do_read(32'h4, 0, d, r);
      chk("lit_strobe_0000", d, 32'h1234_BBBB);

      // Out-of-range accesses
      do_write(32'h40, 32'h1111_1111, 4'hF, 0, 0, 0);
      do_write(32'h8000_0004, 32'h2222_2222, 4'hF, 1, 0, 0);
      do_read(32'h40, 0, d, r);
      chk("lit_oor_rdata", d, 32'h0);
      chk("lit_oor_rresp", 32'(r), 32'(OOR));
      lit[0] = 32'h0; lit[1] = 32'h1234_BBBB; lit[2] = 32'hCAFE_F00D; lit[3] = 32'h0BAD_BEEF;
      for (int i = 0; i < NUM_REGS; i++) begin
         do_read(32'(4 * i), 0, d, r);
         chk("lit_regs_after_oor", d, lit[i]);
      end

      // Back-pressure on both response channels
      do_write(32'h0, 32'h600D_CAFE, 4'hF, 0, 0, 5);
      do_read(32'h0, 5, d, r);
      chk("lit_reg0_backpressure", d, 32'h600D_CAFE);

      // Read captured on the same edge as a write commit sees the old value
      fork
         do_write(32'h4, 32'h7777_7777, 4'hF, 0, 0, 0);
         do_read(32'h4, 0, d, r);
      join
      chk("lit_read_during_write", d, 32'h1234_BBBB);
      do_read(32'h4, 0, d2, r2);
      chk("lit_after_write", d2, 32'h7777_7777);

      // Reset between AW and W handshakes
      @(posedge ACLK); #1;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_AWADDR  = 32'h8;
      af = 1'b0;
      cyc = 0;
      while (!af && cyc < 20) begin
         @(negedge ACLK);
         af = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         @(posedge ACLK); #1;
         cyc++;
      end
      bus.S_AXI_AWVALID = 1'b0;
      chk("inflight_aw_accepted", 32'(af), 32'd1);
      @(posedge ACLK); #3;
      ARESETn = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      mdl_clear();
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge ACLK);
         chk("no_bvalid_after_reset", 32'(bus.S_AXI_BVALID), 32'd0);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         do_read(32'(4 * i), 0, d, r);
         chk("lit_regs_after_reset", d, 32'h0);
      end

      chk("b_responses_balanced", 32'(b_done), 32'(b_exp));
      chk("r_responses_balanced", 32'(r_done), 32'(r_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-003 SHALL have ports ACLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports ARESETn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-006 SHALL have S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 SHALL have S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 SHALL have S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-009 SHALL have S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.

Function
REQ-010 SHALL implement write FSM states W_RST, W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP; outputs decoded from state only.
REQ-011 SHALL drive AWREADY=1 in W_IDLE/W_DATA, WREADY=1 in W_IDLE/W_ADDR, BVALID=1 only in W_RESP; all 0 in W_RST.
REQ-012 SHALL leave W_RST and R_RST for W_IDLE and R_IDLE on the first edge after ARESETn deasserts.
REQ-013 SHALL accept AW and W independently, any order or same cycle, latching AWADDR or WDATA/WSTRB at their handshake edge.
REQ-014 SHALL commit the register write on the edge completing the second handshake, then enter W_RESP; BVALID is high the next cycle (1-cycle latency when AW and W arrive together).
REQ-015 SHALL update only byte lanes with WSTRB[i]=1; WSTRB=0000 is a legal no-op returning OKAY.
REQ-016 SHALL hold BVALID and BRESP stable until BREADY; W_RESP->W_IDLE on BVALID&&BREADY; no new AW/W accepted before.
REQ-017 SHALL implement read FSM states R_RST, R_IDLE (ARREADY=1), R_DATA (RVALID=1, ARREADY=0).
REQ-018 SHALL capture RDATA/RRESP at the AR handshake edge; RVALID high next cycle; held stable until RREADY; R_DATA->R_IDLE on RVALID&&RREADY.
REQ-019 SHALL decode register index from ADDR[2 +: log2(NUM_REGS)]; ADDR[1:0] ignored; any set bit above index field is out-of-range.
REQ-020 SHALL, on simultaneous read capture and write commit to the same register, return the pre-write value.
REQ-021 SHALL ignore AWPROT/ARPROT.
REQ-022 SHALL return BRESP/RRESP = OKAY (2'b00) for all in-range accesses.

Reset
REQ-023 SHALL on ARESETn low immediately clear all registers to 0, FSMs to W_RST/R_RST, all outputs (READY, VALID, RESP, RDATA) to 0.
REQ-024 SHALL drop any in-flight transaction on reset without commit or response.

Configuration
REQ-025 SHALL, with AXIL_SLV_DECERR_EN defined, answer out-of-range writes with BRESP=SLVERR (2'b10), no register change, and out-of-range reads with RRESP=SLVERR, RDATA=0.
REQ-026 SHALL, without AXIL_SLV_DECERR_EN, answer out-of-range accesses with OKAY, discard writes, return RDATA=0.

Structure
REQ-027 SHALL take RESP_OKAY, RESP_SLVERR and FSM state encodings from shared package axi_lite_pkg.
REQ-028 SHALL place the strobed register array and read mux in sub-module axi_lite_slave_regfile.

Verification
REQ-029 SHALL cover: AW 0x4 and W 0x12345678/1111 same cycle -> BVALID next cycle, BRESP=00; read 0x4 -> RDATA=0x12345678, RRESP=00.
REQ-030 SHALL cover: AWVALID 3 cycles before WVALID, and reverse order -> single commit, one BVALID, value read back matches.
REQ-031 SHALL cover: reg1=0x12345678, write 0xAAAABBBB strobe 0011 -> read 0x1234BBBB.
REQ-032 SHALL cover: write/read 0x40 (NUM_REGS=4) -> SLVERR and RDATA=0 with macro; OKAY and RDATA=0 without; all registers unchanged.
REQ-033 SHALL cover: BREADY/RREADY low 5 cycles -> BVALID/RVALID and payload stable, AWREADY/WREADY/ARREADY low throughout.
REQ-034 SHALL cover: ARESETn pulsed after AW handshake, before W -> outputs 0 at once, registers 0, no BVALID after release.
